spi_slave_frontend: RTL

//  SPI slave front end. Sits directly upstream of the single-port RAM: deserialises MOSI

---
 rtl/spi_slave_frontend.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/spi_slave_frontend.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_frontend
// Description : SPI slave front end for a single-port RAM. Deserialises MOSI
//               into {cmd[1:0], data} words with a one-cycle rx_valid strobe
//               and serialises the RAM read byte back out on MISO. Remembers
//               whether a read address has been sent so that read-command
//               frames alternate between READ_ADD and READ_DATA.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_frontend #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
);

    localparam int RX_W   = DATA_W + 2;
    localparam int BCNT_W = $clog2(RX_W);
    localparam int TCNT_W = $clog2(DATA_W);

    localparam logic [BCNT_W-1:0] c_LAST_BIT = BCNT_W'(RX_W - 1);
    localparam logic [TCNT_W-1:0] c_TX_REST  = TCNT_W'(DATA_W - 1);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_CHK_CMD   = 3'd1;
    localparam logic [2:0] c_ST_WRITE     = 3'd2;
    localparam logic [2:0] c_ST_READ_ADD  = 3'd3;
    localparam logic [2:0] c_ST_READ_DATA = 3'd4;

    // Sub-phases of READ_DATA once the command word has been captured
    localparam logic [1:0] c_PH_WAIT  = 2'd0;
    localparam logic [1:0] c_PH_SHIFT = 2'd1;
    localparam logic [1:0] c_PH_DONE  = 2'd2;

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [RX_W-2:0]   r_rx_shift;
    logic [BCNT_W-1:0] r_bit_cnt;
    logic              r_frame_done;
    logic              r_rd_addr_seen;
    logic [1:0]        r_tx_phase;
    logic [DATA_W-1:0] r_tx_shift;
    logic [TCNT_W-1:0] r_tx_cnt;
    logic              r_miso;
    logic [RX_W-1:0]   r_rx_data;
    logic              r_rx_valid;
    logic [RX_W-1:0]   w_rx_word;

    // Word formed by the bits shifted so far plus the bit on MOSI this cycle
    assign w_rx_word = {r_rx_shift, MOSI};

    assign MISO     = r_miso;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; SS_n high always forces IDLE
    always_comb begin
        w_state_nxt = r_state;
        if (SS_n) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE:    w_state_nxt = c_ST_CHK_CMD;
                c_ST_CHK_CMD: begin
                    if (!MOSI) begin
                        w_state_nxt = c_ST_WRITE;
                    end else if (r_rd_addr_seen) begin
                        w_state_nxt = c_ST_READ_DATA;
                    end else begin
                        w_state_nxt = c_ST_READ_ADD;
                    end
                end
                default:      w_state_nxt = r_state;
            endcase
        end
    end

    // Receive shifter, capture strobe, read-address tracking and MISO serialiser
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_shift     <= '0;
            r_bit_cnt      <= '0;
            r_frame_done   <= 1'b0;
            r_rd_addr_seen <= 1'b0;
            r_tx_phase     <= c_PH_WAIT;
            r_tx_shift     <= '0;
            r_tx_cnt       <= '0;
            r_miso         <= 1'b0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (SS_n) begin
                // Frame end or abort: drop any partial word and silence MISO
                r_rx_shift   <= '0;
                r_bit_cnt    <= '0;
                r_frame_done <= 1'b0;
                r_tx_phase   <= c_PH_WAIT;
                r_tx_shift   <= '0;
                r_tx_cnt     <= '0;
                r_miso       <= 1'b0;
            end else begin
                case (r_state)
                    c_ST_CHK_CMD: begin
                        r_rx_shift <= {{(RX_W-2){1'b0}}, MOSI};
                        r_bit_cnt  <= BCNT_W'(1);
                    end
                    c_ST_WRITE, c_ST_READ_ADD, c_ST_READ_DATA: begin
                        if (!r_frame_done) begin
                            r_rx_shift <= w_rx_word[RX_W-2:0];
                            if (r_bit_cnt == c_LAST_BIT) begin
                                r_rx_data    <= w_rx_word;
                                r_rx_valid   <= 1'b1;
                                r_bit_cnt    <= '0;
                                r_frame_done <= 1'b1;
                                if (r_state == c_ST_READ_ADD) begin
                                    r_rd_addr_seen <= 1'b1;
                                end else if (r_state == c_ST_READ_DATA) begin
                                    r_rd_addr_seen <= 1'b0;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + BCNT_W'(1);
                            end
                        end else if (r_state == c_ST_READ_DATA) begin
                            case (r_tx_phase)
                                c_PH_WAIT: begin
                                    if (tx_valid) begin
                                        r_miso     <= tx_data[DATA_W-1];
                                        r_tx_shift <= {tx_data[DATA_W-2:0], 1'b0};
                                        r_tx_cnt   <= c_TX_REST;
                                        r_tx_phase <= c_PH_SHIFT;
                                    end
                                end
                                c_PH_SHIFT: begin
                                    if (r_tx_cnt != '0) begin
                                        r_miso     <= r_tx_shift[DATA_W-1];
                                        r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
                                        r_tx_cnt   <= r_tx_cnt - TCNT_W'(1);
                                    end else begin
                                        r_miso     <= 1'b0;
                                        r_tx_phase <= c_PH_DONE;
                                    end
                                end
                                default: r_miso <= 1'b0;
                            endcase
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
